// File: rtl/gmt_link_serializer.sv
// Serialises the three 64-bit uGMT track words captured on each BX strobe into
// six 32-bit link words, sending 8b10b idles whenever strobe alignment is not established.
module gmt_link_serializer #(
  parameter int unsigned WORDS_PER_BX = 6,
  parameter int unsigned ALIGN_RUN    = 4,
  parameter logic [31:0] IDLE_WORD    = 32'h505050BC,
  parameter logic [3:0]  IDLE_K       = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_enable,
  input  logic             bx_strobe,
  input  logic [2:0][63:0] txdata,
  output logic [31:0]      tx_word,
  output logic [3:0]       tx_k,
  output logic             tx_first,
  output logic             link_up,
  output logic [31:0]      frame_cnt,
  output logic [15:0]      misalign_cnt
);

  localparam int unsigned PH_W   = 3;
  localparam int unsigned GOOD_W = 3;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(WORDS_PER_BX - 1);
  localparam logic [GOOD_W-1:0] GOOD_RUN = GOOD_W'(ALIGN_RUN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [PH_W-1:0]   ph, ph_n;
  logic [GOOD_W-1:0] good, good_n;
  logic [5:0][31:0]  shadow;

  logic [31:0] word_n;
  logic [3:0]  k_n;
  logic        first_n;
  logic        up_n;
  logic [31:0] fcnt_n;
  logic [15:0] mcnt_n;
  logic        send_w0;
  logic        on_time;
  logic        early;
  logic        missing;
  logic [15:0] mcnt_inc;

  assign on_time  = bx_strobe && (ph == PH_LAST);
  assign early    = bx_strobe && (ph != PH_LAST);
  assign missing  = !bx_strobe && (ph == PH_LAST);
  assign mcnt_inc = (misalign_cnt == 16'hFFFF) ? misalign_cnt : misalign_cnt + 16'd1;

  // Phase within the BX: a strobe re-anchors it, otherwise it free-runs modulo WORDS_PER_BX
  always_comb begin
    ph_n = ph + PH_W'(1);
    if (bx_strobe || ph == PH_LAST) ph_n = '0;
  end

  // Next state, alignment score and the next output word
  always_comb begin
    state_n = state;
    good_n  = good;
    word_n  = IDLE_WORD;
    k_n     = IDLE_K;
    first_n = 1'b0;
    fcnt_n  = frame_cnt;
    mcnt_n  = misalign_cnt;
    send_w0 = 1'b0;

    if (!link_enable) begin
      state_n = IDLE;
      good_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ALIGN;
          good_n  = '0;
        end
        ALIGN: begin
          if (bx_strobe) begin
            good_n = on_time ? good + GOOD_W'(1) : GOOD_W'(1);
            if (on_time && (good + GOOD_W'(1) == GOOD_RUN)) begin
              state_n = RUN;
              send_w0 = 1'b1;
            end
          end else if (ph == PH_LAST) begin
            good_n = '0;
          end
        end
        RUN: begin
          if (on_time) begin
            send_w0 = 1'b1;
          end else if (early) begin
            mcnt_n  = mcnt_inc;
            state_n = ALIGN;
            good_n  = GOOD_W'(1);
          end else if (missing) begin
            mcnt_n  = mcnt_inc;
            state_n = ALIGN;
            good_n  = '0;
          end else begin
            word_n = shadow[ph + PH_W'(1)];
            k_n    = 4'b0000;
          end
        end
        default: begin
          state_n = IDLE;
          good_n  = '0;
        end
      endcase
    end

    // w0 bypasses the shadow so it can leave on the clock right after the strobe
    if (send_w0) begin
      word_n  = txdata[0][31:0];
      k_n     = 4'b0000;
      first_n = 1'b1;
      fcnt_n  = frame_cnt + 32'd1;
    end

    up_n = (state_n == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ph           <= '0;
      good         <= '0;
      shadow       <= '0;
      tx_word      <= IDLE_WORD;
      tx_k         <= IDLE_K;
      tx_first     <= 1'b0;
      link_up      <= 1'b0;
      frame_cnt    <= '0;
      misalign_cnt <= '0;
    end else begin
      state        <= state_n;
      ph           <= ph_n;
      good         <= good_n;
      if (bx_strobe) shadow <= txdata;
      tx_word      <= word_n;
      tx_k         <= k_n;
      tx_first     <= first_n;
      link_up      <= up_n;
      frame_cnt    <= fcnt_n;
      misalign_cnt <= mcnt_n;
    end
  end

endmodule
